// File: rtl/scalar_mult_seq_ctrl.sv
// MSB-first double-and-add sequencer for ECC scalar multiplication.
// Issues transfer/double/add commands and tracks their completion interrupts.
module scalar_mult_seq_ctrl #(
    parameter int                KEY_W   = 576,
    parameter int                ADDR_W  = 6,
    parameter logic [ADDR_W-1:0] BASE_X  = 6'h03,
    parameter logic [ADDR_W-1:0] BASE_Y  = 6'h06,
    parameter logic [ADDR_W-1:0] ACC_X   = 6'h21,
    parameter logic [ADDR_W-1:0] ACC_Y   = 6'h27,
    parameter int                TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KEY_W-1:0]  scalar,
    input  logic              interupt_point_add,
    input  logic              interupt_point_double,
    input  logic              interupt_ram_transfer,
    output logic [1:0]        command_add_double,
    output logic              cmd_transfer,
    output logic              read_write_command,
    output logic [ADDR_W-1:0] read_address,
    output logic [ADDR_W-1:0] write_address,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int IDX_W = $clog2(KEY_W);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SCAN, S_LD_X, S_LD_Y, S_DBL, S_ADD, S_NEXT, S_WB_X, S_WB_Y, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] k_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             first_q, first_d;
    logic             error_q, error_d;
    logic             msb0_q, msb0_d;
    logic             load_k;
    logic             waiting;

    // NOTE: registers update with non-blocking (<=) so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            first_q <= 1'b0;
            error_q <= 1'b0;
            msb0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            first_q <= first_d;
            error_q <= error_d;
            msb0_q  <= msb0_d;
        end
    end

    // NOTE: k_q is pure data qualified by the FSM, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_k) k_q <= scalar;
    end

    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    always_comb begin
        state_d            = state_q;
        idx_d              = idx_q;
        timer_d            = timer_q;
        error_d            = error_q;
        msb0_d             = msb0_q;
        load_k             = 1'b0;
        waiting            = 1'b0;
        command_add_double = 2'h0;
        cmd_transfer       = 1'b0;
        read_write_command = 1'b0;
        read_address       = '0;
        write_address      = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_k  = 1'b1;
                    idx_d   = IDX_W'(KEY_W - 1);
                    error_d = 1'b0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (k_q[idx_q]) begin
                    msb0_d  = (idx_q == '0);
                    state_d = S_LD_X;
                    if (idx_q != '0) idx_d = idx_q - 1'b1;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - 1'b1;
                end else begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_LD_X, S_LD_Y: begin
                waiting       = 1'b1;
                cmd_transfer  = first_q;
                read_address  = (state_q == S_LD_X) ? BASE_X : BASE_Y;
                write_address = (state_q == S_LD_X) ? ACC_X : ACC_Y;
                if (interupt_ram_transfer) begin
                    if (state_q == S_LD_X) state_d = S_LD_Y;
                    else                   state_d = msb0_q ? S_WB_X : S_DBL;
                end
            end
            S_DBL: begin
                waiting            = 1'b1;
                command_add_double = first_q ? 2'h2 : 2'h0;
                if (interupt_point_double) state_d = k_q[idx_q] ? S_ADD : S_NEXT;
            end
            S_ADD: begin
                waiting            = 1'b1;
                command_add_double = first_q ? 2'h1 : 2'h0;
                if (interupt_point_add) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == '0) begin
                    state_d = S_WB_X;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = S_DBL;
                end
            end
            S_WB_X, S_WB_Y: begin
                waiting            = 1'b1;
                cmd_transfer       = first_q;
                read_write_command = 1'b1;
                read_address       = (state_q == S_WB_X) ? ACC_X : ACC_Y;
                write_address      = (state_q == S_WB_X) ? ACC_X : ACC_Y;
                if (interupt_ram_transfer) state_d = (state_q == S_WB_X) ? S_WB_Y : S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Timer restarts on every state change; a stalled engine aborts the run.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (waiting) begin
            if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                timer_d = '0;
                error_d = 1'b1;
                state_d = S_DONE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        first_d = (state_d != state_q);
    end

    assign busy  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done  = (state_q == S_DONE);
    assign error = error_q;

endmodule

// File: tb/tb_scalar_mult_seq_ctrl.sv
// Scoreboard bench: a reference model queues the expected command stream per scalar,
// a monitor pops and compares each observed command/done, a responder returns interrupts.
module tb_scalar_mult_seq_ctrl;

    localparam int KEY_W   = 576;
    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 1023;

    localparam logic [1:0] K_XFER = 2'd0;
    localparam logic [1:0] K_DBL  = 2'd1;
    localparam logic [1:0] K_ADD  = 2'd2;
    localparam logic [1:0] K_DONE = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic       rw;
        logic [5:0] rd;
        logic [5:0] wr;
        logic       err;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [KEY_W-1:0]  scalar = '0;
    logic              interupt_point_add = 1'b0;
    logic              interupt_point_double = 1'b0;
    logic              interupt_ram_transfer = 1'b0;
    logic [1:0]        command_add_double;
    logic              cmd_transfer;
    logic              read_write_command;
    logic [ADDR_W-1:0] read_address;
    logic [ADDR_W-1:0] write_address;
    logic              busy;
    logic              done;
    logic              error;

    scalar_mult_seq_ctrl #(
        .KEY_W  (KEY_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .scalar               (scalar),
        .interupt_point_add   (interupt_point_add),
        .interupt_point_double(interupt_point_double),
        .interupt_ram_transfer(interupt_ram_transfer),
        .command_add_double   (command_add_double),
        .cmd_transfer         (cmd_transfer),
        .read_write_command   (read_write_command),
        .read_address         (read_address),
        .write_address        (write_address),
        .busy                 (busy),
        .done                 (done),
        .error                (error)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  cmd_cnt = 0;
    int  dbl_cnt = 0;
    int  add_cnt = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  last_dbl_cyc = 0;
    int  start_cyc = 0;
    bit  in_gap = 1'b0;
    bit  withhold_dbl = 1'b0;
    ev_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ev_t mk_ev(logic [1:0] kind, logic rw, logic [5:0] rd, logic [5:0] wr, logic err);
        ev_t e;
        e.kind = kind; e.rw = rw; e.rd = rd; e.wr = wr; e.err = err;
        return e;
    endfunction

    // Reference model: left-to-right double-and-add expressed directly on the scalar bits.
    function automatic int msb_of(logic [KEY_W-1:0] k);
        for (int i = KEY_W - 1; i >= 0; i--) if (k[i]) return i;
        return -1;
    endfunction

    task automatic model_push(input logic [KEY_W-1:0] k);
        int m;
        m = msb_of(k);
        if (m < 0) begin
            exp_q.push_back(mk_ev(K_DONE, 1'b0, 6'h00, 6'h00, 1'b1));
            return;
        end
        exp_q.push_back(mk_ev(K_XFER, 1'b0, 6'h03, 6'h21, 1'b0));
        exp_q.push_back(mk_ev(K_XFER, 1'b0, 6'h06, 6'h27, 1'b0));
        for (int i = m - 1; i >= 0; i--) begin
            exp_q.push_back(mk_ev(K_DBL, 1'b0, 6'h00, 6'h00, 1'b0));
            if (k[i]) exp_q.push_back(mk_ev(K_ADD, 1'b0, 6'h00, 6'h00, 1'b0));
        end
        exp_q.push_back(mk_ev(K_XFER, 1'b1, 6'h21, 6'h21, 1'b0));
        exp_q.push_back(mk_ev(K_XFER, 1'b1, 6'h27, 6'h27, 1'b0));
        exp_q.push_back(mk_ev(K_DONE, 1'b0, 6'h00, 6'h00, 1'b0));
    endtask

    task automatic observe(input ev_t act, input logic exp_busy);
        ev_t e;
        check("busy_at_event", {63'd0, busy}, {63'd0, exp_busy});
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: got %h expected none (cycle %0d)", act, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event", {48'd0, act}, {48'd0, e});
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_transfer) begin
                cmd_cnt++;
                observe(mk_ev(K_XFER, read_write_command, read_address, write_address, 1'b0), 1'b1);
            end
            if (command_add_double != 2'h0) begin
                cmd_cnt++;
                if (command_add_double == 2'h2) begin
                    dbl_cnt++;
                    last_dbl_cyc = cyc;
                    observe(mk_ev(K_DBL, 1'b0, 6'h00, 6'h00, 1'b0), 1'b1);
                end else if (command_add_double == 2'h1) begin
                    add_cnt++;
                    observe(mk_ev(K_ADD, 1'b0, 6'h00, 6'h00, 1'b0), 1'b1);
                end else begin
                    observe(mk_ev(2'd3, 1'b1, 6'h3f, 6'h3f, 1'b1), 1'b1);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                observe(mk_ev(K_DONE, 1'b0, 6'h00, 6'h00, error), 1'b0);
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Responder: plays the engines, with random latency and irrelevant-interrupt noise.
    task automatic serve();
        logic       is_x;
        logic [1:0] c;
        logic       rw0;
        logic [5:0] rd0, wr0;
        int         d;
        is_x = cmd_transfer;
        c    = command_add_double;
        rw0  = read_write_command;
        rd0  = read_address;
        wr0  = write_address;
        if (!is_x && c == 2'h2 && withhold_dbl) begin
            @(negedge clk);
            return;
        end
        d = $urandom_range(0, 3);
        repeat (d) begin
            interupt_ram_transfer = !is_x && rb();
            interupt_point_add    = (is_x || c == 2'h2) && rb();
            interupt_point_double = (is_x || c == 2'h1) && rb();
            @(negedge clk);
            interupt_ram_transfer = 1'b0;
            interupt_point_add    = 1'b0;
            interupt_point_double = 1'b0;
        end
        if (in_gap) return;
        if (is_x) begin
            check("xfer_hold", {49'd0, read_write_command, read_address, write_address},
                  {49'd0, rw0, rd0, wr0});
            interupt_ram_transfer = 1'b1;
        end else if (c == 2'h2) begin
            interupt_point_double = 1'b1;
        end else begin
            interupt_point_add = 1'b1;
        end
        @(negedge clk);
        interupt_ram_transfer = 1'b0;
        interupt_point_add    = 1'b0;
        interupt_point_double = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (!in_gap && (cmd_transfer || command_add_double != 2'h0)) serve();
        end
    end

    task automatic pulse_start(input logic [KEY_W-1:0] k);
        scalar    = k;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && done_cnt <= d0; i++) @(negedge clk);
        check("done_seen", {63'd0, done_cnt > d0}, 64'd1);
    endtask

    task automatic run_op(input logic [KEY_W-1:0] k);
        int c0, d0, m, exp_cmds;
        logic exp_err;
        m        = msb_of(k);
        exp_err  = (m < 0);
        exp_cmds = (m < 0) ? 0 : 4 + m + $countones(k) - 1;
        c0 = cmd_cnt;
        d0 = done_cnt;
        model_push(k);
        pulse_start(k);
        wait_done(d0, 20000);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("cmd_count", 64'(cmd_cnt - c0), 64'(exp_cmds));
        repeat (3) @(negedge clk);
        check("error_held", {63'd0, error}, {63'd0, exp_err});
        check("idle_after", {62'd0, busy, done}, 64'd0);
        exp_q.delete();
    endtask

    function automatic logic [KEY_W-1:0] rand_key();
        logic [KEY_W-1:0] k;
        for (int i = 0; i < KEY_W; i++) k[i] = rb();
        return k;
    endfunction

    function automatic logic [63:0] outs();
        return {45'd0, command_add_double, cmd_transfer, read_write_command,
                read_address, write_address, busy, done, error};
    endfunction

    initial begin
        logic [KEY_W-1:0] k, k2;
        int d0, a0;

        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // k = 1: loads and write-backs only
        run_op(KEY_W'(1));
        // k = 4'b1011: D, D, A, D, A
        run_op(KEY_W'(11));

        // zero scalar: full scan, error, no commands
        run_op('0);
        check("zero_scan_cycles", 64'(done_cyc - start_cyc), 64'(KEY_W + 1));

        // withheld double completion: timeout abort
        withhold_dbl = 1'b1;
        d0 = done_cnt;
        exp_q.push_back(mk_ev(K_XFER, 1'b0, 6'h03, 6'h21, 1'b0));
        exp_q.push_back(mk_ev(K_XFER, 1'b0, 6'h06, 6'h27, 1'b0));
        exp_q.push_back(mk_ev(K_DBL, 1'b0, 6'h00, 6'h00, 1'b0));
        exp_q.push_back(mk_ev(K_DONE, 1'b0, 6'h00, 6'h00, 1'b1));
        pulse_start(KEY_W'(3));
        wait_done(d0, 3 * TIMEOUT);
        check("timeout_latency", 64'(done_cyc - last_dbl_cyc), 64'(TIMEOUT));
        check("timeout_queue", 64'(exp_q.size()), 64'd0);
        check("timeout_error", {63'd0, error}, 64'd1);
        withhold_dbl = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);

        // reset in the middle of a doubling, then restart
        k = '0;
        k[KEY_W-1] = 1'b1;
        d0 = dbl_cnt;
        model_push(k);
        pulse_start(k);
        for (int i = 0; i < 5000 && !(command_add_double == 2'h2 && dbl_cnt >= d0 + 2); i++)
            @(negedge clk);
        check("reached_dbl", {63'd0, command_add_double == 2'h2}, 64'd1);
        in_gap = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset_outputs", outs(), 64'd0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        check("no_done_after_reset", 64'(done_cnt), 64'(d0));
        in_gap = 1'b0;
        d0 = dbl_cnt;
        a0 = add_cnt;
        run_op(k);
        check("pow2_doubles", 64'(dbl_cnt - d0), 64'(KEY_W - 1));
        check("pow2_adds", 64'(add_cnt - a0), 64'd0);

        // start while busy is ignored
        k  = rand_key();
        k[KEY_W-1] = 1'b1;
        k2 = ~k;
        d0 = done_cnt;
        model_push(k);
        pulse_start(k);
        repeat (5) @(negedge clk);
        pulse_start(k2);
        wait_done(d0, 20000);
        check("busy_start_queue", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        exp_q.delete();

        // random full-width scalars
        repeat (3) run_op(rand_key());
        // random short scalars (varied MSB position)
        repeat (10) run_op(KEY_W'($urandom_range(1, 65535)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
